// File: rtl/dsp_in_pipe_if.sv
// Operand-pipe bus for dsp_in_pipe: stage enables, source inputs, mode
// controls and the three output taps with their status flags.
interface dsp_in_pipe_if #(
    parameter int WIDTH     = 18,
    parameter int MAX_DEPTH = 4,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
);
    logic [MAX_DEPTH-1:0] ce;
    logic                 in_sel;
    logic [WIDTH-1:0]     din;
    logic [WIDTH-1:0]     cin;
    logic                 din_valid;
    logic [DW-1:0]        depth;
    logic                 casc_early;
    logic                 mult_tap;
    logic [WIDTH-1:0]     dout;
    logic [WIDTH-1:0]     cout;
    logic [WIDTH-1:0]     mult_out;
    logic                 dout_valid;
    logic                 settled;

    modport master (
        output ce, in_sel, din, cin, din_valid, depth, casc_early, mult_tap,
        input  dout, cout, mult_out, dout_valid, settled
    );

    modport slave (
        input  ce, in_sel, din, cin, din_valid, depth, casc_early, mult_tap,
        output dout, cout, mult_out, dout_valid, settled
    );
endinterface

// File: rtl/dsp_in_pipe.sv
// Run-time-depth operand input pipeline with per-stage enables, valid
// tracking, cascade/multiplier taps and a settle flag after depth changes.
module dsp_in_pipe #(
    parameter int WIDTH     = 18,
    parameter int MAX_DEPTH = 4,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    dsp_in_pipe_if.slave  bus
);
    localparam logic [DW-1:0] MAX_D  = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] ZERO_D = {DW{1'b0}};
    localparam logic [DW-1:0] ONE_D  = DW'(1);

    logic [WIDTH-1:0] sel_s;
    logic             sel_v_s;
    logic [DW-1:0]    d_s;

    logic [WIDTH-1:0] data_r  [1:MAX_DEPTH];
    logic [MAX_DEPTH:1] vld_r;
    logic [WIDTH-1:0] stg_d_s [1:MAX_DEPTH];
    logic [MAX_DEPTH:1] stg_v_s;
    logic [WIDTH-1:0] tap_d_s [0:MAX_DEPTH];
    logic [MAX_DEPTH:0] tap_v_s;

    logic [DW-1:0]    depth_q_r;
    logic [DW-1:0]    cnt_r;
    logic [WIDTH-1:0] dout_s;
    logic [WIDTH-1:0] first_s;

    // Source select and depth clamp
    always_comb begin
        sel_s   = bus.in_sel ? bus.din : bus.cin;
        sel_v_s = bus.din_valid;
        d_s     = (bus.depth > MAX_D) ? MAX_D : bus.depth;
    end

    // Stage inputs: stage 1 takes the source, stage k takes stage k-1
    always_comb begin
        stg_d_s[1] = sel_s;
        stg_v_s[1] = sel_v_s;
        for (int k = 2; k <= MAX_DEPTH; k++) begin
            stg_d_s[k] = data_r[k-1];
            stg_v_s[k] = vld_r[k-1];
        end
    end

    // Register stages; stages beyond the active depth keep shifting too
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                data_r[k] <= {WIDTH{1'b0}};
            end
            vld_r <= {MAX_DEPTH{1'b0}};
        end else begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                if (bus.ce[k-1]) begin
                    data_r[k] <= stg_d_s[k];
                    vld_r[k]  <= stg_v_s[k];
                end
            end
        end
    end

    // Tap table indexed by effective depth; entry 0 is the passthrough
    always_comb begin
        tap_d_s[0] = sel_s;
        tap_v_s[0] = sel_v_s;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            tap_d_s[k] = data_r[k];
            tap_v_s[k] = vld_r[k];
        end
    end

    // Output taps and settle flag
    always_comb begin
        dout_s         = tap_d_s[d_s];
        first_s        = (d_s == ZERO_D) ? sel_s : data_r[1];
        bus.dout       = dout_s;
        bus.dout_valid = tap_v_s[d_s];
        bus.cout       = bus.casc_early ? first_s : dout_s;
        bus.mult_out   = bus.mult_tap   ? first_s : dout_s;
        bus.settled    = (cnt_r == ZERO_D) && (d_s == depth_q_r);
    end

    // Settle counter: reload on a depth change, count down on ce[0]
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q_r <= ZERO_D;
            cnt_r     <= ZERO_D;
        end else begin
            depth_q_r <= d_s;
            if (d_s != depth_q_r) begin
                cnt_r <= d_s;
            end else if (bus.ce[0] && (cnt_r != ZERO_D)) begin
                cnt_r <= cnt_r - ONE_D;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_dsp_in_pipe.sv
// Directed self-checking bench for dsp_in_pipe (WIDTH=18, MAX_DEPTH=4).
module tb_dsp_in_pipe;
    localparam int WIDTH     = 18;
    localparam int MAX_DEPTH = 4;
    localparam int DW        = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    dsp_in_pipe_if #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .DW(DW)) bus ();

    dsp_in_pipe #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] selv(input int c);
        return (c % 2 == 0) ? 18'h00011 : 18'h3FFFE;
    endfunction

    int dl [6]     = '{0, 1, 2, 3, 4, 7};
    int exp_se [11] = '{0, 0, 0, 1, 2, 3, 3, 3, 6, 7, 8};
    int exp_st [5]  = '{0, 0, 0, 0, 1};

    initial begin
        bus.ce = 4'hF; bus.in_sel = 1'b1; bus.din = 18'h0; bus.cin = 18'h0;
        bus.din_valid = 1'b0; bus.depth = 3'd4; bus.casc_early = 1'b0; bus.mult_tap = 1'b0;
        tick(); tick();
        // Reset state: registers cleared, depth 4 not yet settled
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_settled", bus.settled, 0);

        // Depth sweep including clamp (7 behaves as 4); taps at stage 1
        for (int i = 0; i < 6; i++) begin
            int eff;
            eff = (dl[i] > 4) ? 4 : dl[i];
            bus.depth = 3'(dl[i]); bus.ce = 4'hF; bus.in_sel = 1'b1;
            bus.din_valid = 1'b1; bus.casc_early = 1'b1; bus.mult_tap = 1'b1;
            rst = 1'b1; tick(); rst = 1'b0;
            for (int c = 0; c < 8; c++) begin
                bus.din = 18'(c + 1);
                #1;
                chk("sweep_dout", bus.dout, (c >= eff) ? (c + 1 - eff) : 0);
                chk("sweep_valid", bus.dout_valid, (c >= eff) ? 1 : 0);
                chk("sweep_cout", bus.cout, (eff == 0) ? (c + 1) : c);
                chk("sweep_mult", bus.mult_out, (eff == 0) ? (c + 1) : c);
                chk("sweep_settled", bus.settled, ((eff == 0) || (c >= eff + 1)) ? 1 : 0);
                tick();
            end
        end

        // Source/tap mux at depth 2 with toggling in_sel
        bus.depth = 3'd2; bus.din = 18'h00011; bus.cin = 18'h3FFFE;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            logic ce_m, mt_m;
            ce_m = (c == 2 || c == 3 || c == 6);
            mt_m = (c == 2 || c == 3 || c == 7);
            bus.in_sel = (c % 2 == 0); bus.casc_early = ce_m; bus.mult_tap = mt_m;
            #1;
            if (c >= 2) begin
                chk("mux_dout", bus.dout, selv(c - 2));
                chk("mux_cout", bus.cout, ce_m ? selv(c - 1) : selv(c - 2));
                chk("mux_mult", bus.mult_out, mt_m ? selv(c - 1) : selv(c - 2));
            end
            tick();
        end

        // Stage 2 stalled for two cycles at depth 3
        bus.depth = 3'd3; bus.in_sel = 1'b1; bus.casc_early = 1'b0; bus.mult_tap = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 11; c++) begin
            bus.din = 18'(c + 1);
            bus.ce = (c == 4 || c == 5) ? 4'b1101 : 4'b1111;
            #1;
            chk("stall_dout", bus.dout, exp_se[c]);
            tick();
        end

        // Settle: 0->3, 3->0, 0->3 reloaded to 1 mid-count, then ce[0] hold
        bus.ce = 4'hF; bus.depth = 3'd0;
        rst = 1'b1; tick(); rst = 1'b0;
        #1; chk("settle_d0", bus.settled, 1); tick();
        bus.depth = 3'd3;
        for (int c = 0; c < 5; c++) begin
            #1; chk("settle_0to3", bus.settled, exp_st[c]); tick();
        end
        bus.depth = 3'd0;
        #1; chk("settle_3to0_chg", bus.settled, 0); tick();
        #1; chk("settle_3to0_done", bus.settled, 1); tick();
        bus.depth = 3'd3;
        #1; chk("settle_rl_chg", bus.settled, 0); tick();
        #1; chk("settle_rl_cnt3", bus.settled, 0); tick();
        bus.depth = 3'd1;
        #1; chk("settle_rl_to1", bus.settled, 0); tick();
        #1; chk("settle_rl_cnt1", bus.settled, 0); tick();
        #1; chk("settle_rl_done", bus.settled, 1); tick();
        bus.depth = 3'd2; bus.ce = 4'hE;
        #1; chk("settle_ce_chg", bus.settled, 0); tick();
        #1; chk("settle_ce_cnt2", bus.settled, 0); tick();
        #1; chk("settle_ce_hold", bus.settled, 0);
        bus.ce = 4'hF; tick();
        #1; chk("settle_ce_cnt1", bus.settled, 0); tick();
        #1; chk("settle_ce_done", bus.settled, 1); tick();

        // Reset mid-stream with ce low discards a full pipe
        bus.depth = 3'd4; bus.ce = 4'hF; bus.din_valid = 1'b1; bus.in_sel = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.din = 18'(5 + c);
            tick();
        end
        bus.din = 18'd9;
        #1; chk("full_dout", bus.dout, 5); chk("full_valid", bus.dout_valid, 1);
        rst = 1'b1; bus.ce = 4'h0; tick(); rst = 1'b0; bus.ce = 4'hF;
        for (int c = 0; c < 5; c++) begin
            bus.din = 18'(10 + c);
            #1;
            chk("mrst_dout", bus.dout, (c == 4) ? 10 : 0);
            chk("mrst_valid", bus.dout_valid, (c == 4) ? 1 : 0);
            chk("mrst_settled", bus.settled, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
